cpu_if: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU, directly upstream of the decode stage.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction and PC+2 for decode.
- Applies redirects from decode's branch unit, stalls from the hazard unit, and HLT detection.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 37 +++
 rtl/cpu_if.sv | 112 +++++++++++
 tb/tb_cpu_if.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by fetch, decode and execute.
package cpu_pkg;

    typedef logic [15:0] word_t;

    localparam logic [3:0] OPC_HLT   = 4'hF;
    localparam word_t      NOP_INSTR = 16'h0000;   // ADD R0,R0,R0
    localparam word_t      RESET_PC  = 16'h0000;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  valid;
    } ifid_t;

    // Instructions are halfword aligned, so every PC load clears bit 0.
    function automatic word_t pc_align(input word_t a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds when en=0, loads a bubble (pc kept) on flush.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t ifid_d, ifid_q;

    always_comb begin
        ifid_d = ifid_q;
        if (en) begin
            if (flush) begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end else begin
                ifid_d = d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_INSTR, pc: 16'h0000, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;

endmodule

// File: rtl/cpu_if.sv
// Instruction fetch stage: PC, RUN/HALTED FSM and IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module cpu_if
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTake,
    input  logic [15:0] pcBranch,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    output logic [15:0] instrID,
    output logic [15:0] pcID,
    output logic        validID,
    output logic        halted,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt
);

    localparam logic [0:0] ST_RUN    = RUN;
    localparam logic [0:0] ST_HALTED = HALTED;

    logic [0:0] state_d, state_q;
    word_t      pc_d, pc_q;
    word_t      pc_inc;
    logic       is_hlt;
    logic       flush;
    ifid_t      fetch, ifid;

    assign pc_inc = pc_q + 16'd2;
    assign is_hlt = (imemData[15:12] == OPC_HLT);
    assign fetch  = '{instr: imemData, pc: pc_inc, valid: 1'b1};

    // Stall freezes everything; a redirect outranks a fetched HLT so a
    // wrong-path halt never takes effect.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        flush   = 1'b0;
        if (!stall) begin
            if (state_q == ST_HALTED) begin
                flush = 1'b1;
            end else if (branchTake) begin
                pc_d  = pc_align(pcBranch);
                flush = 1'b1;
            end else if (is_hlt) begin
                state_d = ST_HALTED;
            end else begin
                pc_d = pc_align(pc_inc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= pc_align(RESET_PC);
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .flush (flush),
        .d     (fetch),
        .q     (ifid)
    );

    assign imemAddr = pc_q;
    assign instrID  = ifid.instr;
    assign pcID     = ifid.pc;
    assign validID  = ifid.valid;
    assign halted   = (state_q == ST_HALTED);

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (!stall && branchTake && state_q == ST_RUN && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;
`else
    assign stallCnt = 16'h0000;
    assign flushCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_if.sv
// Directed bench for cpu_if: fetch, stall, redirect, HLT, wrap, async reset.
module tb_cpu_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branchTake;
    logic [15:0] pcBranch;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic [15:0] instrID;
    logic [15:0] pcID;
    logic        validID;
    logic        halted;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:32767];

    always #5 clk = ~clk;

    assign imemData = mem[imemAddr[15:1]];

    cpu_if dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branchTake (branchTake),
        .pcBranch   (pcBranch),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .instrID    (instrID),
        .pcID       (pcID),
        .validID    (validID),
        .halted     (halted),
        .stallCnt   (stallCnt),
        .flushCnt   (flushCnt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] addr,
                              input logic [15:0] ins, input logic [15:0] pc,
                              input logic vld, input logic hlt);
        check({tag, ".imemAddr"}, imemAddr, addr);
        check({tag, ".instrID"}, instrID, ins);
        check({tag, ".pcID"}, pcID, pc);
        check({tag, ".validID"}, {15'd0, validID}, {15'd0, vld});
        check({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] s, input logic [15:0] f);
`ifdef IF_PERF_CNT_EN
        check({tag, ".stallCnt"}, stallCnt, s);
        check({tag, ".flushCnt"}, flushCnt, f);
`else
        check({tag, ".stallCnt"}, stallCnt, 16'h0000);
        check({tag, ".flushCnt"}, flushCnt, 16'h0000);
`endif
    endtask

    initial begin
        // Default word {1, addr[11:0]} never decodes as HLT.
        for (int i = 0; i < 32768; i++) begin
            mem[i] = {4'h1, 11'(i), 1'b0};
        end
        mem[16'h0000 >> 1] = 16'h1234;
        mem[16'h0002 >> 1] = 16'h2345;
        mem[16'h0010 >> 1] = 16'hF000;
        mem[16'h0042 >> 1] = 16'hF042;

        rst_n = 1'b0; stall = 1'b0; branchTake = 1'b0; pcBranch = 16'h0000;
        #2;
        check_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_cnt("reset", 16'd0, 16'd0);
        #10 rst_n = 1'b1;

        step(); check_ifid("fetch0", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);
        step(); check_ifid("fetch1", 16'h0004, 16'h2345, 16'h0004, 1'b1, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_ifid("stall", 16'h0004, 16'h2345, 16'h0004, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step(); check_ifid("resume", 16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0);
        step(); check_ifid("seq8", 16'h0008, 16'h1006, 16'h0008, 1'b1, 1'b0);
        step(); check_ifid("seqA", 16'h000A, 16'h1008, 16'h000A, 1'b1, 1'b0);

        branchTake = 1'b1; pcBranch = 16'h0040;
        step(); check_ifid("br_bubble", 16'h0040, 16'h0000, 16'h000A, 1'b0, 1'b0);
        branchTake = 1'b0;
        step(); check_ifid("br_target", 16'h0042, 16'h1040, 16'h0042, 1'b1, 1'b0);
        check_cnt("cnt1", 16'd3, 16'd1);

        // HLT at 0x42 under stall+branch: nothing moves.
        stall = 1'b1; branchTake = 1'b1; pcBranch = 16'h0081;
        step(); check_ifid("stall_br_hlt", 16'h0042, 16'h1040, 16'h0042, 1'b1, 1'b0);
        stall = 1'b0;
        step(); check_ifid("br_cancels_hlt", 16'h0080, 16'h0000, 16'h0042, 1'b0, 1'b0);
        branchTake = 1'b0;
        step(); check_ifid("after_cancel", 16'h0082, 16'h1080, 16'h0082, 1'b1, 1'b0);
        stall = 1'b1;
        step(); check_ifid("stall5", 16'h0082, 16'h1080, 16'h0082, 1'b1, 1'b0);
        stall = 1'b0;
        check_cnt("cnt2", 16'd5, 16'd2);

        branchTake = 1'b1; pcBranch = 16'hFFFE;
        step(); check_ifid("br_fffe", 16'hFFFE, 16'h0000, 16'h0082, 1'b0, 1'b0);
        branchTake = 1'b0;
        step(); check_ifid("wrap", 16'h0000, 16'h1FFE, 16'h0000, 1'b1, 1'b0);
        step(); check_ifid("post_wrap", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);

        branchTake = 1'b1; pcBranch = 16'h0010;
        step(); check_ifid("br_10", 16'h0010, 16'h0000, 16'h0002, 1'b0, 1'b0);
        branchTake = 1'b0;
        step(); check_ifid("hlt", 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1);
        // Redirects while halted are ignored and not counted.
        branchTake = 1'b1; pcBranch = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            step(); check_ifid("halted", 16'h0010, 16'h0000, 16'h0012, 1'b0, 1'b1);
        end
        branchTake = 1'b0;
        check_cnt("cnt3", 16'd5, 16'd4);

        #2 rst_n = 1'b0;
        #1;
        check_ifid("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_cnt("async_rst", 16'd0, 16'd0);
        #2 rst_n = 1'b1;
        step(); check_ifid("after_rst", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
